// File: rtl/psram_arbiter.sv
// Two-port APB arbiter sharing one PSRAM controller between instruction fetch (port 0) and data (port 1).
// Define PSRAM_ARB_RR_EN for round-robin tie-break; otherwise port 1 wins contention.
module psram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [ADDR_WIDTH-1:0] s0_paddr,
  input  logic [DATA_WIDTH-1:0] s0_pdata,
  input  logic                  s0_psel,
  input  logic                  s0_penable,
  input  logic                  s0_pwrite,
  input  logic [3:0]            s0_pstb,
  output logic [DATA_WIDTH-1:0] s0_prdata,
  output logic                  s0_pready,
  output logic                  s0_perr,
  input  logic [ADDR_WIDTH-1:0] s1_paddr,
  input  logic [DATA_WIDTH-1:0] s1_pdata,
  input  logic                  s1_psel,
  input  logic                  s1_penable,
  input  logic                  s1_pwrite,
  input  logic [3:0]            s1_pstb,
  output logic [DATA_WIDTH-1:0] s1_prdata,
  output logic                  s1_pready,
  output logic                  s1_perr,
  output logic [ADDR_WIDTH-1:0] m_paddr,
  output logic [DATA_WIDTH-1:0] m_pdata,
  output logic                  m_pwrite,
  output logic [3:0]            m_pstb,
  output logic                  m_psel,
  output logic                  m_penable,
  input  logic [DATA_WIDTH-1:0] m_prdata,
  input  logic                  m_pready,
  input  logic                  m_perr,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_q;
  logic   gnt_q, gnt_d;
  logic   last_q;
  logic   m_psel_q, m_penable_q, busy_q;
  logic   gnt_sel;
  logic   in_access;

  always_comb begin
    gnt_d = gnt_q;
    if (s0_psel && s1_psel) begin
`ifdef PSRAM_ARB_RR_EN
      gnt_d = ~last_q;
`else
      // Data port always wins; last is still tracked but does not steer the grant.
      gnt_d = last_q | 1'b1;
`endif
    end else if (s0_psel) begin
      gnt_d = 1'b0;
    end else if (s1_psel) begin
      gnt_d = 1'b1;
    end
  end

  assign gnt_sel = gnt_q ? s1_psel : s0_psel;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s0_psel || s1_psel) begin
            gnt_q       <= gnt_d;
            state_q     <= SETUP;
            m_psel_q    <= 1'b1;
            m_penable_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SETUP: begin
          state_q     <= ACCESS;
          m_penable_q <= 1'b1;
        end
        ACCESS: begin
          // A requester walking away aborts without crediting it as served.
          if (!gnt_sel) begin
            state_q     <= IDLE;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (m_pready || m_perr) begin
            state_q     <= IDLE;
            last_q      <= gnt_q;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          m_psel_q    <= 1'b0;
          m_penable_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign m_paddr   = gnt_q ? s1_paddr  : s0_paddr;
  assign m_pdata   = gnt_q ? s1_pdata  : s0_pdata;
  assign m_pwrite  = gnt_q ? s1_pwrite : s0_pwrite;
  assign m_pstb    = gnt_q ? s1_pstb   : s0_pstb;
  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign busy      = busy_q;

  assign in_access = (state_q == ACCESS);
  assign s0_pready = in_access && !gnt_q && s0_psel && s0_penable && m_pready;
  assign s0_perr   = in_access && !gnt_q && s0_psel && s0_penable && m_perr;
  assign s1_pready = in_access &&  gnt_q && s1_psel && s1_penable && m_pready;
  assign s1_perr   = in_access &&  gnt_q && s1_psel && s1_penable && m_perr;
  assign s0_prdata = m_prdata;
  assign s1_prdata = m_prdata;

endmodule
